// File: rtl/prbs7_lane_checker.sv
// Self-synchronizing PRBS-7 (x^7+x^6+1) lane checker with an ACQUIRE/LOCKED lock FSM.
// Errored words are flagged, with their mismatched-bit count, only while the lane is locked.
module prbs7_lane_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter bit INVERT       = 1'b0,
    parameter int LOCK_WORDS   = 16,
    parameter int UNLOCK_WORDS = 4
) (
    input  logic                              dclk_i,
    input  logic                              rst_n_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic                              data_valid_i,
    input  logic                              enable_i,
    output logic                              err_o,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   err_bits_o,
    output logic                              locked_o,
    output logic                              lock_lost_o
);

    localparam int W      = DATA_WIDTH;
    localparam int BITS_W = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0]      INV_MASK   = {W{INVERT}};
    localparam logic [7:0]        LOCK_CNT   = 8'(LOCK_WORDS);
    localparam logic [7:0]        UNLOCK_CNT = 8'(UNLOCK_WORDS);
    localparam logic [BITS_W-1:0] ALL_BITS   = BITS_W'(DATA_WIDTH);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [W-1:0]      cur, prev;
    logic              v1;
    logic [2*W-1:0]    stream;
    logic [W-1:0]      mismatch;
    logic [BITS_W-1:0] nbits;
    logic              word_err;
    logic [7:0]        clean_cnt, clean_next, clean_inc;
    logic [7:0]        err_cnt, err_cnt_next, err_inc;
    logic              primed, primed_next;
    logic              err_d, lost_d;
    logic [BITS_W-1:0] bits_d;

    // Stage 1: capture qualified words; idle or disabled cycles leave a bubble.
    always_ff @(posedge dclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur  <= '0;
            prev <= '0;
            v1   <= 1'b0;
        end else if (!enable_i) begin
            v1 <= 1'b0;
        end else if (data_valid_i) begin
            prev <= cur;
            cur  <= data_i ^ INV_MASK;
            v1   <= 1'b1;
        end else begin
            v1 <= 1'b0;
        end
    end

    assign stream = {cur, prev};

    // Stage 2: each bit of cur must equal the XOR of the bits 6 and 7 positions earlier.
    always_comb begin
        mismatch = '0;
        nbits    = '0;
        for (int i = 0; i < W; i++) begin
            mismatch[i] = stream[W+i] ^ stream[W+i-6] ^ stream[W+i-7];
            nbits       = nbits + {{(BITS_W-1){1'b0}}, mismatch[i]};
        end
        // A zero run longer than 6 cannot occur in PRBS-7, so an all-zero word is fully wrong.
        if (cur == '0) begin
            nbits = ALL_BITS;
        end
    end

    assign word_err  = (nbits != '0);
    assign clean_inc = clean_cnt + 8'd1;
    assign err_inc   = err_cnt + 8'd1;

    always_ff @(posedge dclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ACQUIRE;
            clean_cnt   <= '0;
            err_cnt     <= '0;
            primed      <= 1'b0;
            err_o       <= 1'b0;
            err_bits_o  <= '0;
            lock_lost_o <= 1'b0;
        end else begin
            state       <= state_next;
            clean_cnt   <= clean_next;
            err_cnt     <= err_cnt_next;
            primed      <= primed_next;
            err_o       <= err_d;
            err_bits_o  <= bits_d;
            lock_lost_o <= lost_d;
        end
    end

    // The first checked word after reset or re-enable only primes prev and is not counted.
    always_comb begin
        state_next   = state;
        clean_next   = clean_cnt;
        err_cnt_next = err_cnt;
        primed_next  = primed;
        if (!enable_i) begin
            state_next   = ACQUIRE;
            clean_next   = '0;
            err_cnt_next = '0;
            primed_next  = 1'b0;
        end else if (v1) begin
            if (!primed) begin
                primed_next = 1'b1;
            end else begin
                case (state)
                    ACQUIRE: begin
                        if (word_err) begin
                            clean_next = '0;
                        end else if (clean_inc == LOCK_CNT) begin
                            state_next   = LOCKED;
                            clean_next   = '0;
                            err_cnt_next = '0;
                        end else begin
                            clean_next = clean_inc;
                        end
                    end
                    LOCKED: begin
                        if (!word_err) begin
                            err_cnt_next = '0;
                        end else if (err_inc == UNLOCK_CNT) begin
                            state_next   = ACQUIRE;
                            clean_next   = '0;
                            err_cnt_next = '0;
                        end else begin
                            err_cnt_next = err_inc;
                        end
                    end
                    default: state_next = ACQUIRE;
                endcase
            end
        end
    end

    always_comb begin
        err_d    = enable_i && v1 && primed && (state == LOCKED) && word_err;
        bits_d   = err_d ? nbits : '0;
        lost_d   = err_d && (err_inc == UNLOCK_CNT);
        locked_o = (state == LOCKED);
    end

endmodule

// File: tb/tb_prbs7_lane_checker.sv
// Directed bench for prbs7_lane_checker: instance a checks as-is, instance b has INVERT=1.
// Each scenario task drives the PRBS-7 stream from seed 7'h7F and checks hand-derived expectations.
module tb_prbs7_lane_checker;

    logic       dclk = 1'b0;
    logic       rst_n;
    logic       data_valid;
    logic       enable;
    logic [7:0] data_a, data_b;
    logic       err_a, locked_a, lost_a;
    logic       err_b, locked_b, lost_b;
    logic [3:0] bits_a, bits_b;

    int total = 0;
    int bad   = 0;
    int widx  = 0;
    logic prbs_bits [2048];

    always #5 dclk = ~dclk;

    prbs7_lane_checker #(.DATA_WIDTH(8), .INVERT(1'b0), .LOCK_WORDS(16), .UNLOCK_WORDS(4)) dut_a (
        .dclk_i(dclk), .rst_n_i(rst_n), .data_i(data_a), .data_valid_i(data_valid),
        .enable_i(enable), .err_o(err_a), .err_bits_o(bits_a), .locked_o(locked_a),
        .lock_lost_o(lost_a)
    );

    prbs7_lane_checker #(.DATA_WIDTH(8), .INVERT(1'b1), .LOCK_WORDS(16), .UNLOCK_WORDS(4)) dut_b (
        .dclk_i(dclk), .rst_n_i(rst_n), .data_i(data_b), .data_valid_i(data_valid),
        .enable_i(enable), .err_o(err_b), .err_bits_o(bits_b), .locked_o(locked_b),
        .lock_lost_o(lost_b)
    );

    // Word idx of the reference stream, bit 0 earliest; w(0)=8'h7F, w(1)=8'h20, w(2)=8'h18.
    function automatic logic [7:0] w(input int idx);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = prbs_bits[idx*8+j];
        return r;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic v);
        data_a     = a;
        data_b     = b;
        data_valid = v;
        @(posedge dclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        data_valid = 1'b0;
        data_a     = 8'h00;
        data_b     = 8'h00;
        repeat (2) @(posedge dclk);
        #2 rst_n = 1'b1;
        @(posedge dclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; data_valid = 1'b0; data_a = 8'h00; data_b = 8'h00;
        #1;
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset err_o: got %b want 0", err_a); end
        total++; if (bits_a !== 4'd0) begin bad++; $display("FAIL reset err_bits_o: got %0d want 0", bits_a); end
        total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL reset locked_o: got %b want 0", locked_a); end
        total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL reset lock_lost_o: got %b want 0", lost_a); end
        do_reset();
    endtask

    // Priming word + 16 clean words: lock is visible in the sample after the 18th send.
    task automatic test_lock_seq();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            send(w(i), ~w(i), 1'b1);
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL lock_seq err_o word %0d: got %b want 0", i, err_a); end
            total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL lock_seq lock_lost_o word %0d: got %b want 0", i, lost_a); end
            total++; if (locked_a !== (i == 17)) begin bad++; $display("FAIL lock_seq locked_o word %0d: got %b want %b", i, locked_a, (i == 17)); end
            total++; if (locked_b !== (i == 17)) begin bad++; $display("FAIL lock_seq_inv locked_o word %0d: got %b want %b", i, locked_b, (i == 17)); end
            total++; if (err_b !== 1'b0) begin bad++; $display("FAIL lock_seq_inv err_o word %0d: got %b want 0", i, err_b); end
        end
        widx = 18;
    endtask

    task automatic test_single_flip();
        for (int k = 0; k < 3; k++) begin
            send(w(widx), ~w(widx), 1'b1); widx++;
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL flip_pre err_o: got %b want 0", err_a); end
        end
        send(w(widx) ^ 8'h01, 8'h00, 1'b1); widx++;
        send(w(widx), 8'h00, 1'b1); widx++;
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL flip0 err_o: got %b want 1", err_a); end
        total++; if (bits_a !== 4'd3) begin bad++; $display("FAIL flip0 err_bits_o: got %0d want 3", bits_a); end
        send(w(widx), 8'h00, 1'b1); widx++;
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL flip0_after err_o: got %b want 0", err_a); end
        total++; if (bits_a !== 4'd0) begin bad++; $display("FAIL flip0_after err_bits_o: got %0d want 0", bits_a); end
        send(w(widx) ^ 8'h80, 8'h00, 1'b1); widx++;
        send(w(widx), 8'h00, 1'b1); widx++;
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL flip7_a err_o: got %b want 1", err_a); end
        total++; if (bits_a !== 4'd1) begin bad++; $display("FAIL flip7_a err_bits_o: got %0d want 1", bits_a); end
        send(w(widx), 8'h00, 1'b1); widx++;
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL flip7_b err_o: got %b want 1", err_a); end
        total++; if (bits_a !== 4'd2) begin bad++; $display("FAIL flip7_b err_bits_o: got %0d want 2", bits_a); end
        send(w(widx), 8'h00, 1'b1); widx++;
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL flip7_after err_o: got %b want 0", err_a); end
        total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL flip locked_o: got %b want 1", locked_a); end
        total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL flip lock_lost_o: got %b want 0", lost_a); end
    endtask

    // Four all-zero words drop lock; restarting the stream from w(0) relocks after 16 clean words.
    task automatic test_zero_unlock();
        send(8'h00, 8'hFF, 1'b1);
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL zero0 err_o: got %b want 0", err_a); end
        for (int z = 1; z < 4; z++) begin
            send(8'h00, 8'hFF, 1'b1);
            total++; if (err_a !== 1'b1) begin bad++; $display("FAIL zero%0d err_o: got %b want 1", z, err_a); end
            total++; if (bits_a !== 4'd8) begin bad++; $display("FAIL zero%0d err_bits_o: got %0d want 8", z, bits_a); end
            total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL zero%0d lock_lost_o: got %b want 0", z, lost_a); end
            total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL zero%0d locked_o: got %b want 1", z, locked_a); end
        end
        send(w(0), ~w(0), 1'b1);
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL zero4 err_o: got %b want 1", err_a); end
        total++; if (bits_a !== 4'd8) begin bad++; $display("FAIL zero4 err_bits_o: got %0d want 8", bits_a); end
        total++; if (lost_a !== 1'b1) begin bad++; $display("FAIL zero4 lock_lost_o: got %b want 1", lost_a); end
        total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL zero4 locked_o: got %b want 0", locked_a); end
        for (int i = 1; i < 18; i++) begin
            send(w(i), ~w(i), 1'b1);
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL relock err_o word %0d: got %b want 0", i, err_a); end
            total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL relock lock_lost_o word %0d: got %b want 0", i, lost_a); end
            total++; if (locked_a !== (i == 17)) begin bad++; $display("FAIL relock locked_o word %0d: got %b want %b", i, locked_a, (i == 17)); end
        end
    endtask

    task automatic test_invert_mismatch();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            send(~w(i), ~w(i), 1'b1);
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL invmis err_o word %0d: got %b want 0", i, err_a); end
            total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL invmis locked_o word %0d: got %b want 0", i, locked_a); end
            total++; if (locked_b !== (i >= 17)) begin bad++; $display("FAIL invmis_b locked_o word %0d: got %b want %b", i, locked_b, (i >= 17)); end
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(w(i), ~w(i), 1'b1);
            total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL gaps locked_o valid %0d: got %b want 0", i, locked_a); end
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL gaps err_o valid %0d: got %b want 0", i, err_a); end
            send(8'h00, 8'h00, 1'b0);
            total++; if (locked_a !== (i == 16)) begin bad++; $display("FAIL gaps locked_o gap %0d: got %b want %b", i, locked_a, (i == 16)); end
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL gaps err_o gap %0d: got %b want 0", i, err_a); end
        end
        send(w(17), ~w(17), 1'b1);
        total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL gaps final locked_o: got %b want 1", locked_a); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 18; i++) send(w(i), ~w(i), 1'b1);
        send(w(18) ^ 8'h01, 8'h00, 1'b1);
        send(w(19), 8'h00, 1'b1);
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL areset_pre err_o: got %b want 1", err_a); end
        total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL areset_pre locked_o: got %b want 1", locked_a); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL areset err_o: got %b want 0", err_a); end
        total++; if (bits_a !== 4'd0) begin bad++; $display("FAIL areset err_bits_o: got %0d want 0", bits_a); end
        total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL areset locked_o: got %b want 0", locked_a); end
        total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL areset lock_lost_o: got %b want 0", lost_a); end
        #1 rst_n = 1'b1;
        @(posedge dclk);
        #1;
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int i = 0; i < 18; i++) send(w(i), ~w(i), 1'b1);
        total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL en_pre locked_o: got %b want 1", locked_a); end
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send(w(18 + k), ~w(18 + k), 1'b1);
            total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL en_off locked_o cycle %0d: got %b want 0", k, locked_a); end
            total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL en_off lock_lost_o cycle %0d: got %b want 0", k, lost_a); end
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL en_off err_o cycle %0d: got %b want 0", k, err_a); end
        end
        enable = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send(w(i), ~w(i), 1'b1);
            total++; if (locked_a !== (i == 17)) begin bad++; $display("FAIL en_relock locked_o word %0d: got %b want %b", i, locked_a, (i == 17)); end
            total++; if (err_a !== 1'b0) begin bad++; $display("FAIL en_relock err_o word %0d: got %b want 0", i, err_a); end
        end
    endtask

    initial begin
        for (int n = 0; n < 2048; n++) begin
            if (n < 7) prbs_bits[n] = 1'b1;
            else       prbs_bits[n] = prbs_bits[n-6] ^ prbs_bits[n-7];
        end
        test_reset();
        test_lock_seq();
        test_single_flip();
        test_zero_unlock();
        test_invert_mismatch();
        test_valid_gaps();
        test_async_reset();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
